// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: state encoding, PC-source selects,
// default datapath width and the canonical NOP.
package riscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_SRC_IMM   = 2'b01;
   localparam logic [1:0] PC_SRC_JALR  = 2'b10;
   localparam logic [1:0] PC_SRC_RSVD  = 2'b11;  // behaves as PC_SRC_PLUS4

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_TRAP  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection for the fetch stage. All adds wrap modulo
// 2^XLEN; the JALR target has bit 0 forced low before use.
module next_pc_sel #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] imm_ext,
   input  logic [XLEN-1:0] jalr_target,
   output logic [XLEN-1:0] next_pc,
   output logic            target_misaligned
);
   import riscv_pkg::*;

   // jalr_target[0] is discarded by design
   logic w_unused;
   assign w_unused = jalr_target[0];

   // Select the redirect target; reserved encoding falls back to sequential
   always_comb begin
      next_pc = pc + XLEN'(4);
      case (pc_src)
         PC_SRC_IMM:  next_pc = pc + imm_ext;
         PC_SRC_JALR: next_pc = {jalr_target[XLEN-1:1], 1'b0};
         default:     next_pc = pc + XLEN'(4);
      endcase
   end

   // Only 4-byte aligned instruction fetch is supported
   assign target_misaligned = next_pc[1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with an instruction memory
// that may insert wait states, holds the fetched word for decode and forms
// the next PC from the control select. A misaligned redirect halts fetch
// until reset.
module fetch_unit #(
   parameter int unsigned XLEN      = riscv_pkg::XLEN,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] imm_ext,
   input  logic [XLEN-1:0] jalr_target,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            instr_valid,
   output logic            misaligned
);
   import riscv_pkg::*;

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_instr;
   logic            r_valid;
   logic            r_misaligned;

   logic [XLEN-1:0] w_next_pc;
   logic            w_target_misaligned;

   next_pc_sel #(
      .XLEN (XLEN)
   ) u_next_pc_sel (
      .pc                (r_pc),
      .pc_src            (pc_src),
      .imm_ext           (imm_ext),
      .jalr_target       (jalr_target),
      .next_pc           (w_next_pc),
      .target_misaligned (w_target_misaligned)
   );

   // Fetch FSM and architectural fetch registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pc         <= XLEN'(RESET_PC);
         r_instr      <= NOP_INSTR;
         r_valid      <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_FETCH;
            S_FETCH: begin
               // stall is deliberately ignored here so the fetch completes
               if (imem_ready) begin
                  r_instr <= imem_rdata;
                  r_valid <= 1'b1;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!stall) begin
                  if (w_target_misaligned) begin
                     r_misaligned <= 1'b1;
                     r_valid      <= 1'b0;
                     r_state      <= S_TRAP;
                  end else begin
                     r_pc    <= w_next_pc;
                     r_valid <= 1'b0;
                     r_instr <= NOP_INSTR;
                     r_state <= S_FETCH;
                  end
               end
            end
            S_TRAP:  r_state <= S_TRAP;  // only reset leaves the trap
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Moore outputs and the link-value adder
   always_comb begin
      imem_req    = (r_state == S_FETCH);
      imem_addr   = r_pc;
      pc          = r_pc;
      pc_plus4    = r_pc + XLEN'(4);
      instr       = r_instr;
      instr_valid = r_valid;
      misaligned  = r_misaligned;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, branch/JALR redirect,
// wait states and stall, misaligned trap, reset mid-fetch and PC wrap.
module tb_fetch_unit;

   localparam logic [31:0] MEMX = 32'h1234_5678;  // instruction word = addr ^ MEMX
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic [1:0]  pc_src;
   logic [31:0] imm_ext;
   logic [31:0] jalr_target;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        misaligned;

   int n_checks;
   int n_fail;

   fetch_unit u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .pc_src      (pc_src),
      .imm_ext     (imm_ext),
      .jalr_target (jalr_target),
      .instr       (instr),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .misaligned  (misaligned)
   );

   // Memory model: word depends on address so wrong fetches are visible
   assign imem_rdata = imem_addr ^ MEMX;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      imem_ready  = 1'b1;
      stall       = 1'b0;
      pc_src      = 2'b00;
      imm_ext     = '0;
      jalr_target = '0;

      // Reset
      repeat (3) @(negedge clk);
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, NOP);
      check("rst_valid", {31'b0, instr_valid}, 32'h0);
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_misal", {31'b0, misaligned}, 32'h0);
      rst_n = 1'b1;
      check("idle_req", {31'b0, imem_req}, 32'h0);
      step();
      check("first_req", {31'b0, imem_req}, 32'h1);
      check("first_addr", imem_addr, 32'h0);

      // Sequential, zero-wait
      for (int k = 0; k < 4; k++) begin
         check("seq_fetch_addr", imem_addr, 32'(k * 4));
         check("seq_fetch_valid", {31'b0, instr_valid}, 32'h0);
         step();
         check("seq_exec_valid", {31'b0, instr_valid}, 32'h1);
         check("seq_exec_instr", instr, 32'(k * 4) ^ MEMX);
         check("seq_exec_pc", pc, 32'(k * 4));
         check("seq_exec_pc4", pc_plus4, 32'(k * 4 + 4));
         check("seq_exec_req", {31'b0, imem_req}, 32'h0);
         step();
         check("seq_nop", instr, NOP);
      end

      // Branch back, then JALR with bit 0 set
      check("br_fetch_addr", imem_addr, 32'h10);
      step();
      pc_src  = 2'b01;
      imm_ext = 32'hFFFF_FFF8;
      step();
      check("br_target", imem_addr, 32'h08);
      check("br_req", {31'b0, imem_req}, 32'h1);
      pc_src = 2'b00;
      step();
      pc_src      = 2'b10;
      jalr_target = 32'h0000_0101;
      step();
      check("jalr_target", imem_addr, 32'h100);
      pc_src = 2'b00;

      // Three wait states, then a five-cycle stall with a bad redirect pending
      imem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("wait_req", {31'b0, imem_req}, 32'h1);
         check("wait_valid", {31'b0, instr_valid}, 32'h0);
      end
      imem_ready = 1'b1;
      step();
      check("wait_done_valid", {31'b0, instr_valid}, 32'h1);
      check("wait_done_instr", instr, 32'h100 ^ MEMX);
      stall   = 1'b1;
      pc_src  = 2'b01;
      imm_ext = 32'h6;
      for (int k = 0; k < 5; k++) begin
         step();
         check("stall_pc", pc, 32'h100);
         check("stall_instr", instr, 32'h100 ^ MEMX);
         check("stall_req", {31'b0, imem_req}, 32'h0);
         check("stall_valid", {31'b0, instr_valid}, 32'h1);
      end
      stall  = 1'b0;
      pc_src = 2'b00;
      step();
      check("unstall_addr", imem_addr, 32'h104);
      check("unstall_req", {31'b0, imem_req}, 32'h1);
      check("unstall_misal", {31'b0, misaligned}, 32'h0);

      // Misaligned redirect from pc=0 (reset asserted while fetching)
      rst_n = 1'b0;
      #1;
      check("async_rst_req", {31'b0, imem_req}, 32'h0);
      check("async_rst_pc", pc, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      step();
      check("mis_pre_valid", {31'b0, instr_valid}, 32'h1);
      pc_src  = 2'b01;
      imm_ext = 32'h6;
      step();
      check("mis_flag", {31'b0, misaligned}, 32'h1);
      check("mis_valid", {31'b0, instr_valid}, 32'h0);
      check("mis_req", {31'b0, imem_req}, 32'h0);
      check("mis_pc", pc, 32'h0);
      pc_src = 2'b00;
      repeat (3) step();
      check("trap_req", {31'b0, imem_req}, 32'h0);
      check("trap_flag", {31'b0, misaligned}, 32'h1);
      check("trap_pc", pc, 32'h0);

      // Reset mid-fetch with ready low
      rst_n = 1'b0;
      step();
      check("trap_cleared", {31'b0, misaligned}, 32'h0);
      rst_n      = 1'b1;
      imem_ready = 1'b0;
      step();
      check("midf_req", {31'b0, imem_req}, 32'h1);
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("midf_rst_req", {31'b0, imem_req}, 32'h0);
      check("midf_rst_valid", {31'b0, instr_valid}, 32'h0);
      step();
      rst_n      = 1'b1;
      imem_ready = 1'b1;

      // PC wrap at the top of the address space
      step();
      step();
      pc_src      = 2'b10;
      jalr_target = 32'hFFFF_FFFD;
      step();
      check("wrap_fetch_addr", imem_addr, 32'hFFFF_FFFC);
      pc_src = 2'b11;  // reserved select behaves as sequential
      step();
      check("wrap_instr", instr, 32'hFFFF_FFFC ^ MEMX);
      check("wrap_pc4", pc_plus4, 32'h0);
      step();
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_req", {31'b0, imem_req}, 32'h1);
      check("wrap_misal", {31'b0, misaligned}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
